// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline (between ID and MEM).
//   Registers the ID->EX bus, evaluates the one-hot ALU op, drives the data
//   SRAM request, and runs a 32-step restoring divider that writes HI/LO.
//   While a division is in progress the stage raises stallreq_for_ex.
//
// Ports:
//   clk              pipeline clock
//   rst              synchronous active-high reset
//   stall[5:0]       global stall vector (bit 2 = EX register, bit 3 = MEM register)
//   id_to_ex_bus     156-bit bus from ID
//   ex_to_mem_bus    76-bit bus to MEM {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, result}
//   ex_to_id_bus     38-bit forwarding bus {rf_we, rf_waddr, result}
//   ex_is_load       instruction in EX is a load (sel_rf_res & rf_we)
//   stallreq_for_ex  divider busy request
//   data_sram_*      data SRAM request (en, wen, addr = result, wdata = store data)
//
// Divider states:
//   state | meaning
//   IDLE  | no division running; a div/divu in EX latches operands and starts
//   BUSY  | one shift-subtract step per cycle, count 0..31, HI/LO written at 31
//   DONE  | result written; wait for EX to advance so the div is not restarted

module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [155:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_id_bus,
  output logic         ex_is_load,
  output logic         stallreq_for_ex,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // ---------------------------------------------------------------------------
  // ID->EX register
  // ---------------------------------------------------------------------------
  logic [155:0] id_ex_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
    end else if (stall[2] && !stall[3]) begin
      id_ex_q <= '0;
    end else if (!stall[2]) begin
      id_ex_q <= id_to_ex_bus;
    end
  end

  logic [31:0] pc;
  logic [11:0] alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] store_data;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [1:0]  div_op;
  logic [1:0]  hilo_op;

  assign {pc, alu_op, src1, src2, store_data, data_ram_en, data_ram_wen,
          sel_rf_res, rf_we, rf_waddr, div_op, hilo_op} = id_ex_q;

  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5:4], stall[1:0]};

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] alu_res;

  always_comb begin
    alu_res = '0;
    if      (alu_op[11]) alu_res = src1 + src2;
    else if (alu_op[10]) alu_res = src1 - src2;
    else if (alu_op[9])  alu_res = {31'd0, $signed(src1) < $signed(src2)};
    else if (alu_op[8])  alu_res = {31'd0, src1 < src2};
    else if (alu_op[7])  alu_res = src1 & src2;
    else if (alu_op[6])  alu_res = ~(src1 | src2);
    else if (alu_op[5])  alu_res = src1 | src2;
    else if (alu_op[4])  alu_res = src1 ^ src2;
    else if (alu_op[3])  alu_res = src2 << src1[4:0];
    else if (alu_op[2])  alu_res = src2 >> src1[4:0];
    else if (alu_op[1])  alu_res = $unsigned($signed(src2) >>> src1[4:0]);
    else if (alu_op[0])  alu_res = {src2[15:0], 16'd0};
  end

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  div_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] quo_q, quo_d;     // dividend magnitude, shifts into quotient
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;     // divisor magnitude
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dsr_zero_q, dsr_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] step_tmp;
  logic [32:0] step_diff;
  logic        step_ge;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic        is_signed;

  assign step_tmp  = {rem_q, quo_q[31]};
  assign step_diff = step_tmp - {1'b0, dsr_q};
  assign step_ge   = (step_tmp >= {1'b0, dsr_q});
  assign step_rem  = step_ge ? step_diff[31:0] : step_tmp[31:0];
  assign step_quo  = {quo_q[30:0], step_ge};
  assign is_signed = div_op[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dsr_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dsr_q      <= dsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dsr_zero_q <= dsr_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dsr_d      = dsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dsr_zero_d = dsr_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      IDLE: begin
        if (div_op != 2'b00) begin
          quo_d      = (is_signed && src1[31]) ? -src1 : src1;
          dsr_d      = (is_signed && src2[31]) ? -src2 : src2;
          neg_quo_d  = is_signed && (src1[31] ^ src2[31]);
          neg_rem_d  = is_signed && src1[31];
          dsr_zero_d = (src2 == 32'd0);
          rem_d      = '0;
          count_d    = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        quo_d   = step_quo;
        rem_d   = step_rem;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = DONE;
          // A zero divisor leaves the remainder equal to the dividend magnitude,
          // so HI = src1 falls out of the sign fix-up; only LO needs forcing.
          lo_d = dsr_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -step_quo : step_quo);
          hi_d = neg_rem_q ? -step_rem : step_rem;
        end
      end
      DONE: begin
        if (!stall[2]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stallreq_for_ex = (div_op != 2'b00) && (state_q != DONE);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [31:0] ex_result;

  assign ex_result = hilo_op[1] ? hi_q :
                     hilo_op[0] ? lo_q : alu_res;

  assign ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we,
                            rf_waddr, ex_result};
  assign ex_to_id_bus    = {rf_we, rf_waddr, ex_result};
  assign ex_is_load      = sel_rf_res & rf_we;
  assign data_sram_en    = data_ram_en;
  assign data_sram_wen   = data_ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = store_data;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  localparam logic [11:0] OP_ADD  = 12'b1000_0000_0000;
  localparam logic [11:0] OP_SUB  = 12'b0100_0000_0000;
  localparam logic [11:0] OP_SLT  = 12'b0010_0000_0000;
  localparam logic [11:0] OP_SLTU = 12'b0001_0000_0000;
  localparam logic [11:0] OP_AND  = 12'b0000_1000_0000;
  localparam logic [11:0] OP_NOR  = 12'b0000_0100_0000;
  localparam logic [11:0] OP_OR   = 12'b0000_0010_0000;
  localparam logic [11:0] OP_XOR  = 12'b0000_0001_0000;
  localparam logic [11:0] OP_SLL  = 12'b0000_0000_1000;
  localparam logic [11:0] OP_SRL  = 12'b0000_0000_0100;
  localparam logic [11:0] OP_SRA  = 12'b0000_0000_0010;
  localparam logic [11:0] OP_LUI  = 12'b0000_0000_0001;
  localparam logic [11:0] OP_NONE = 12'b0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   ext_stall;
  logic [5:0]   stall;
  logic [155:0] id_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         ex_is_load;
  logic         stallreq_for_ex;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Minimal pipeline controller: an EX stall request freezes PC..EX.
  assign stall = stallreq_for_ex ? 6'b001111 : ext_stall;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  typedef struct {
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [155:0] mk(input logic [31:0] pc, input logic [11:0] op,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] sd, input logic en,
                                      input logic [3:0] wen, input logic sel,
                                      input logic we, input logic [4:0] wa,
                                      input logic [1:0] dop, input logic [1:0] hl);
    return {pc, op, s1, s2, sd, en, wen, sel, we, wa, dop, hl};
  endfunction

  function automatic logic [155:0] mflo();
    return mk(32'h0000_0100, OP_NONE, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 2'b00, 2'b01);
  endfunction

  function automatic logic [155:0] mfhi();
    return mk(32'h0000_0104, OP_NONE, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 2'b00, 2'b10);
  endfunction

  // Starts a division (one cycle latch into EX) and counts cycles with
  // stallreq_for_ex high; returns with EX in DONE and the request low.
  task automatic run_div(input logic [1:0] dop, input logic [31:0] s1,
                         input logic [31:0] s2, output int high);
    id_bus = mk(32'h0000_00F0, OP_NONE, s1, s2, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, dop, 2'b00);
    ext_stall = 6'b0;
    tick();
    high = 0;
    while (stallreq_for_ex && high < 100) begin
      high++;
      tick();
    end
    if (high >= 100) begin
      errors++;
      $display("FAIL div_timeout actual=%0d required=33", high);
    end
  endtask

  task automatic read_hilo(input string name, input logic [31:0] lo, input logic [31:0] hi);
    id_bus = mflo();
    tick();
    check({name, "_lo"}, {44'd0, ex_to_mem_bus[31:0]}, {44'd0, lo});
    id_bus = mfhi();
    tick();
    check({name, "_hi"}, {44'd0, ex_to_mem_bus[31:0]}, {44'd0, hi});
  endtask

  initial begin
    int high;
    logic [75:0] exp_mem;
    logic [155:0] bus_a;
    logic [155:0] bus_b;

    vecs[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[2]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[4]  = '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5]  = '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[6]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[7]  = '{OP_NOR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F};
    vecs[8]  = '{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[9]  = '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[10] = '{OP_SLL,  32'h0000_0024, 32'h0000_0001, 32'h0000_0010};
    vecs[11] = '{OP_SRL,  32'h0000_0008, 32'h8000_0000, 32'h0080_0000};
    vecs[12] = '{OP_SRA,  32'h0000_0008, 32'h8000_0000, 32'hFF80_0000};
    vecs[13] = '{OP_LUI,  32'h1234_5678, 32'h0000_ABCD, 32'hABCD_0000};
    vecs[14] = '{OP_NONE, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000};

    rst = 1'b1;
    ext_stall = 6'b0;
    id_bus = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_mem_bus", ex_to_mem_bus, 76'd0);
    check("rst_id_bus", {38'd0, ex_to_id_bus}, 76'd0);
    check("rst_sram", {6'd0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load, stallreq_for_ex}, 76'd0);

    // Table-driven ALU vectors
    for (int i = 0; i < 15; i++) begin
      id_bus = mk(32'h0040_0000 + 32'(i * 4), vecs[i].op, vecs[i].s1, vecs[i].s2, 32'd0,
                  1'b0, 4'h0, 1'b0, 1'b1, 5'(i + 1), 2'b00, 2'b00);
      tick();
      exp_mem = {32'h0040_0000 + 32'(i * 4), 1'b0, 4'h0, 1'b0, 1'b1, 5'(i + 1), vecs[i].res};
      check($sformatf("alu_mem_%0d", i), ex_to_mem_bus, exp_mem);
      check($sformatf("alu_id_%0d", i), {38'd0, ex_to_id_bus}, {38'd0, 1'b1, 5'(i + 1), vecs[i].res});
    end

    // Store
    id_bus = mk(32'h0040_1000, OP_ADD, 32'h0000_1000, 32'h0000_0004, 32'hDEAD_BEEF,
                1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00);
    tick();
    check("store_sram", {6'd0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load},
          {6'd0, 1'b1, 4'hF, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0});

    // Load
    id_bus = mk(32'h0040_1004, OP_ADD, 32'h0000_2000, 32'h0000_0008, 32'd0,
                1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 2'b00, 2'b00);
    tick();
    check("load_flag", {43'd0, ex_is_load, data_sram_addr}, {43'd0, 1'b1, 32'h0000_2008});

    // Bubble and hold
    bus_a = mk(32'h0040_2000, OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 2'b00, 2'b00);
    bus_b = mk(32'h0040_2004, OP_OR, 32'd8, 32'd1, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 2'b00, 2'b00);
    id_bus = bus_a;
    tick();
    id_bus = bus_b;
    ext_stall = 6'b000111;
    tick();
    check("bubble_bus", ex_to_mem_bus, 76'd0);
    check("bubble_no_div", {75'd0, stallreq_for_ex}, 76'd0);
    ext_stall = 6'b0;
    id_bus = bus_a;
    tick();
    id_bus = bus_b;
    ext_stall = 6'b001111;
    tick();
    check("hold_bus", ex_to_mem_bus, {32'h0040_2000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'd3});
    ext_stall = 6'b0;

    // divu 100/7
    run_div(2'b01, 32'd100, 32'd7, high);
    check("divu_stall_cycles", 76'(high), 76'd33);
    read_hilo("divu_100_7", 32'd14, 32'd2);

    // div -7/2
    run_div(2'b10, 32'hFFFF_FFF9, 32'd2, high);
    check("div_stall_cycles", 76'(high), 76'd33);
    read_hilo("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    // divu 5/0, with an external stall held while in DONE
    run_div(2'b01, 32'd5, 32'd0, high);
    ext_stall = 6'b001111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("done_hold_req_%0d", k), {75'd0, stallreq_for_ex}, 76'd0);
      check($sformatf("done_hold_pc_%0d", k), {44'd0, ex_to_mem_bus[75:44]}, {44'd0, 32'h0000_00F0});
    end
    ext_stall = 6'b0;
    read_hilo("divu_5_0", 32'hFFFF_FFFF, 32'd5);

    // div -5/0
    run_div(2'b10, 32'hFFFF_FFFB, 32'd0, high);
    read_hilo("div_m5_0", 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Reset at T+10 of a division
    id_bus = mk(32'h0000_00F0, OP_NONE, 32'd100, 32'd7, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 2'b01, 2'b00);
    tick();
    for (int k = 0; k < 10; k++) tick();
    check("rst_mid_busy", {75'd0, stallreq_for_ex}, 76'd1);
    rst = 1'b1;
    id_bus = mflo();
    tick();
    rst = 1'b0;
    check("rst_mid_req", {75'd0, stallreq_for_ex}, 76'd0);
    check("rst_mid_bus", ex_to_mem_bus, 76'd0);
    read_hilo("rst_mid", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
